// File: rtl/dot_product_sequencer.sv
// Buffers up to DEPTH 4-bit operand pairs, then drives an external sequential multiplier
// once per pair and accumulates the products into a dot-product sum.
module dot_product_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SUM_W = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [3:0]       i_load_a,
  input  logic [3:0]       i_load_b,
  input  logic             i_go,
  output logic             o_mul_start,
  output logic [3:0]       o_mul_a,
  output logic [3:0]       o_mul_b,
  input  logic [7:0]       i_mul_product,
  input  logic             i_mul_done,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_sum_valid,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAccum, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_count;
  logic [IdxW-1:0]   r_index;
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  r_sum;
  logic              r_sum_valid;
  logic              r_done_q;
  logic [3:0]        r_mul_a, r_mul_b;
  logic [3:0]        r_buf_a [DEPTH];
  logic [3:0]        r_buf_b [DEPTH];

  logic              w_load_fire;
  logic              w_done_rise;
  logic [CntW-1:0]   w_idx_plus;
  logic              w_more;
  logic [IdxW-1:0]   w_wr_idx;
  logic [IdxW-1:0]   w_rd_next;

  assign o_load_ready = (r_state == StIdle) && (r_count < CntW'(DEPTH)) && !i_go;
  assign w_load_fire  = i_load_valid && o_load_ready;
  // Only a fresh rising edge counts; a done level left over from the previous op is ignored.
  assign w_done_rise  = i_mul_done && !r_done_q;
  assign w_idx_plus   = CntW'(r_index) + CntW'(1);
  assign w_more       = w_idx_plus < r_count;
  assign w_wr_idx     = r_count[IdxW-1:0];
  assign w_rd_next    = w_idx_plus[IdxW-1:0];

  assign o_mul_start  = (r_state == StIssue);
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_sum        = r_sum;
  assign o_sum_valid  = r_sum_valid;
  assign o_busy       = (r_state != StIdle);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_go) w_state_next = (r_count == '0) ? StDone : StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (w_done_rise) w_state_next = StAccum;
      StAccum: w_state_next = w_more ? StIssue : StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count     <= '0;
      r_index     <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_done_q    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else begin
      r_done_q    <= i_mul_done;
      r_sum_valid <= 1'b0;
      if (w_load_fire) begin
        r_buf_a[w_wr_idx] <= i_load_a;
        r_buf_b[w_wr_idx] <= i_load_b;
        r_count           <= r_count + CntW'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (i_go) begin
            r_acc   <= '0;
            r_index <= '0;
            r_mul_a <= r_buf_a[0];
            r_mul_b <= r_buf_b[0];
          end
        end
        StAccum: begin
          r_acc   <= r_acc + SUM_W'(i_mul_product);
          r_index <= r_index + IdxW'(1);
          // Operands for the next pair are staged here so they are stable when ISSUE starts.
          if (w_more) begin
            r_mul_a <= r_buf_a[w_rd_next];
            r_mul_b <= r_buf_b[w_rd_next];
          end
        end
        StDone: begin
          r_sum       <= r_acc;
          r_sum_valid <= 1'b1;
          r_count     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a behavioural sequential multiplier
// that can be overridden to drive mul_done/mul_product by hand.
module tb_dot_product_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_a = '0, load_b = '0;
  logic       go = 1'b0;
  logic       mul_start;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_product;
  logic       mul_done;
  logic [9:0] sum;
  logic       sum_valid;
  logic       busy;

  logic       man_mode = 1'b0;
  logic       man_done = 1'b0;
  logic [7:0] man_prod = '0;
  logic       m_done = 1'b0, m_busy = 1'b0;
  logic [1:0] m_cnt = '0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [7:0] m_prod = '0;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_start = 0;
  int         n_sv = 0;
  logic [7:0] start_log [64];
  int         base;

  assign mul_done    = man_mode ? man_done : m_done;
  assign mul_product = man_mode ? man_prod : m_prod;

  always #5 clk = ~clk;

  dot_product_sequencer #(.DEPTH(4), .SUM_W(10)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_load_valid  (load_valid),
    .o_load_ready  (load_ready),
    .i_load_a      (load_a),
    .i_load_b      (load_b),
    .i_go          (go),
    .o_mul_start   (mul_start),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_product (mul_product),
    .i_mul_done    (mul_done),
    .o_sum         (sum),
    .o_sum_valid   (sum_valid),
    .o_busy        (busy)
  );

  // Multiplier model: done drops on start, rises 4 cycles later and then holds with the product.
  always @(posedge clk) begin
    if (rst) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= '0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 2'd3;
      m_a    <= mul_a;
      m_b    <= mul_b;
    end else if (m_busy) begin
      if (m_cnt == 2'd0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_a * m_b;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (mul_start) begin
      if (n_start < 64) start_log[n_start] = {mul_a, mul_b};
      n_start++;
    end
    if (sum_valid) n_sv++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_pair(input logic [3:0] a, input logic [3:0] b, input logic exp_ready);
    load_valid = 1'b1;
    load_a = a;
    load_b = b;
    #1;
    check("load_ready", 32'(load_ready), 32'(exp_ready));
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_sum(input string tag, input int budget);
    int waited = 0;
    while (sum_valid !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(sum_valid), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_sum_valid", 32'(sum_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_mul_ab", 32'({mul_a, mul_b}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_load_ready", 32'(load_ready), 1);

    // Four mixed pairs: 15 + 225 + 0 + 14 = 254.
    base = n_start;
    load_pair(4'd3, 4'd5, 1'b1);
    load_pair(4'd15, 4'd15, 1'b1);
    load_pair(4'd0, 4'd9, 1'b1);
    load_pair(4'd7, 4'd2, 1'b1);
    pulse_go();
    check("run_busy", 32'(busy), 1);
    wait_sum("sum254_timeout", 200);
    check("sum254", 32'(sum), 254);
    repeat (4) @(negedge clk);
    check("sum254_starts", 32'(n_start - base), 4);
    check("start0", 32'(start_log[base]), 32'h35);
    check("start1", 32'(start_log[base + 1]), 32'hFF);
    check("start2", 32'(start_log[base + 2]), 32'h09);
    check("start3", 32'(start_log[base + 3]), 32'h72);
    check("sum254_pulses", 32'(n_sv), 1);
    check("sum_hold", 32'(sum), 254);
    check("sum_valid_low", 32'(sum_valid), 0);
    check("idle_busy", 32'(busy), 0);

    // Full buffer of maxima; the fifth load must be refused.
    base = n_start;
    repeat (4) load_pair(4'd15, 4'd15, 1'b1);
    load_pair(4'd1, 4'd1, 1'b0);
    pulse_go();
    wait_sum("sum900_timeout", 200);
    check("sum900", 32'(sum), 900);
    @(negedge clk);
    check("sum900_starts", 32'(n_start - base), 4);

    // Empty-buffer go: sum_valid two cycles after go is sampled, no multiply.
    base = n_start;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("empty_sv_early", 32'(sum_valid), 0);
    check("empty_busy", 32'(busy), 1);
    @(negedge clk);
    check("empty_sv", 32'(sum_valid), 1);
    check("empty_sum", 32'(sum), 0);
    check("empty_starts", 32'(n_start - base), 0);

    // go and load_valid together: load refused, run uses only (2,3).
    @(negedge clk);
    base = n_start;
    load_pair(4'd2, 4'd3, 1'b1);
    load_valid = 1'b1;
    load_a = 4'd5;
    load_b = 4'd5;
    go = 1'b1;
    #1;
    check("go_load_ready", 32'(load_ready), 0);
    @(negedge clk);
    load_valid = 1'b0;
    go = 1'b0;
    wait_sum("sum6_timeout", 200);
    check("sum6", 32'(sum), 6);
    @(negedge clk);
    check("sum6_starts", 32'(n_start - base), 1);

    // Stale done level held through ISSUE/WAIT must not be taken as completion.
    man_mode = 1'b1;
    man_done = 1'b1;
    man_prod = 8'd99;
    @(negedge clk);
    base = n_start;
    load_pair(4'd4, 4'd5, 1'b1);
    pulse_go();
    check("stale_issue_start", 32'(mul_start), 1);
    check("stale_issue_ab", 32'({mul_a, mul_b}), 32'h45);
    repeat (4) @(negedge clk);
    check("stale_wait_busy", 32'(busy), 1);
    check("stale_wait_start", 32'(mul_start), 0);
    check("stale_wait_ab", 32'({mul_a, mul_b}), 32'h45);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    man_prod = 8'd20;
    wait_sum("stale_timeout", 50);
    check("stale_sum", 32'(sum), 20);
    check("stale_starts", 32'(n_start - base), 1);
    man_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT of the second pair aborts the run and empties the buffer.
    base = n_start;
    load_pair(4'd1, 4'd2, 1'b1);
    load_pair(4'd3, 4'd4, 1'b1);
    pulse_go();
    for (int i = 0; i < 100 && n_start < base + 2; i++) @(negedge clk);
    check("abort_reached_wait", 32'(n_start - base), 2);
    base = n_sv;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_sum_valid", 32'(sum_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_pulse", 32'(n_sv - base), 0);
    check("abort_sum_hold", 32'(sum), 0);
    base = n_start;
    load_pair(4'd6, 4'd7, 1'b1);
    pulse_go();
    wait_sum("sum42_timeout", 200);
    check("sum42", 32'(sum), 42);
    @(negedge clk);
    check("sum42_starts", 32'(n_start - base), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the operand-pair buffer capacity (legal range 1..4).
REQ-002 Parameter SUM_W, default 10, SHALL set the accumulator width (at least 8 + ceil(log2(DEPTH))).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 load_valid  input  1  SHALL offer an operand pair on load_A/load_B.
REQ-006 load_ready  output  1  SHALL indicate that the buffer accepts a pair this cycle.
REQ-007 load_A, load_B  input  4 each  SHALL carry the unsigned operand pair.
REQ-008 go  input  1  SHALL request evaluation of all buffered pairs.
REQ-009 mul_start  output  1  SHALL be the start request to the downstream sequential multiplier.
REQ-010 mul_A, mul_B  output  4 each  SHALL carry the operands for the current multiply.
REQ-011 mul_product  input  8  SHALL carry the multiplier result.
REQ-012 mul_done  input  1  SHALL carry the multiplier done level.
REQ-013 sum  output  SUM_W  SHALL carry the dot-product result.
REQ-014 sum_valid  output  1  SHALL pulse for one cycle when sum is updated.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, ISSUE, WAIT, ACCUM and DONE.
REQ-017 A pair SHALL be written at buffer index count, and count incremented, when load_valid && load_ready.
REQ-018 load_ready SHALL equal (state==IDLE) && (count<DEPTH) && !go; a load offered while the buffer is full SHALL be dropped with no state change.
REQ-019 go in IDLE with count==0: the block SHALL clear sum to 0, go to DONE, and pulse sum_valid.
REQ-020 go in IDLE with count>0: the block SHALL clear the accumulator, set index=0 and go to ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle: mul_start=1, mul_A/mul_B = buffer[index]; next state WAIT.
REQ-022 mul_A/mul_B SHALL hold buffer[index] stable from ISSUE through ACCUM.
REQ-023 Rising-edge detect: a registered copy done_q of mul_done SHALL be kept; completion = mul_done && !done_q.
REQ-024 WAIT SHALL ignore a mul_done level that is already high, left over from the previous operation; only completion SHALL advance WAIT to ACCUM.
REQ-025 ACCUM SHALL add zero-extended mul_product to the accumulator and increment index.
REQ-026 ACCUM SHALL go to ISSUE if index+1<count, otherwise to DONE.
REQ-027 ACCUM SHALL be the required one-cycle gap that lets the multiplier return to its idle state before the next start.
REQ-028 DONE SHALL last one cycle: sum := accumulator, sum_valid=1, count:=0, next state IDLE.
REQ-029 The accumulator SHALL never overflow for legal DEPTH/SUM_W (max 4*225=900 < 1024).
REQ-030 load_valid and go SHALL be ignored outside IDLE.
REQ-031 mul_start SHALL be 0 outside ISSUE.
REQ-032 sum SHALL hold its value between sum_valid pulses.
REQ-033 Sequencer overhead SHALL be 2 cycles per pair (ISSUE, ACCUM) plus 1 DONE cycle per run.

Reset
REQ-034 On reset: state=IDLE, count=0, index=0, accumulator=0, done_q=0, sum=0, sum_valid=0, mul_start=0, mul_A=0, mul_B=0, busy=0.
REQ-035 Reset asserted mid-run SHALL abort immediately: no sum_valid pulse and the buffer emptied.
REQ-036 The first go after reset SHALL start a clean run.

Verification
REQ-037 Load (3,5),(15,15),(0,9),(7,2), then go, with the multiplier attached -> four mul_start pulses in order; single sum_valid with sum=254.
REQ-038 Load four (15,15) pairs, then go -> sum=900; a fifth load while full sees load_ready=0 and is not stored.
REQ-039 go with an empty buffer -> sum_valid exactly 2 cycles after go sampled, sum=0, mul_start never asserted.
REQ-040 mul_done held high from a prior op when ISSUE fires -> no early ACCUM; accumulation occurs only after mul_done falls then rises.
REQ-041 reset pulsed during the WAIT of the 2nd pair -> busy=0, sum=0, no sum_valid; then a new run with 1 pair (6,7) -> sum=42.
REQ-042 load_valid and go high in the same IDLE cycle with count=1 (2,3) -> load refused, run uses only (2,3), sum=6.
